// File: rtl/shift_unit_pipe_pkg.sv
// Shared types and helpers for the RV64 shift functional unit.
// Opcode bit 2 selects a W-variant, bit 1 selects arithmetic fill, bit 0 selects a right shift.
package shift_pkg;

    localparam int XLEN    = 64;
    localparam int SHAMT_W = 6;

    typedef enum logic [2:0] {
        OP_SLL  = 3'b000,
        OP_SRL  = 3'b001,
        OP_SRA  = 3'b011,
        OP_SLLW = 3'b100,
        OP_SRLW = 3'b101,
        OP_SRAW = 3'b111
    } shift_op_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// Issue and writeback handshake bundle of the shift unit.
// The master side is the issue port and writeback bus; the slave side is the unit.
interface shift_unit_pipe_if #(parameter int TAG_W = 5);
    import shift_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_op;
    logic [XLEN-1:0]     in_rs1;
    logic [SHAMT_W-1:0]  in_shamt;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_result;
    logic [TAG_W-1:0]    out_tag;

    modport master (
        output in_valid, in_op, in_rs1, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );

endinterface

// File: rtl/shift_unit_pipe_stage.sv
// Combinational partial shifter: applies shift-amount bits [HI:LO] to a 64-bit value.
// Right shifts pull the fill bit in from the top; left shifts always fill with zero.
module shift_stage
    import shift_pkg::*;
#(
    parameter int LO = 0,
    parameter int HI = 2
) (
    input  logic [XLEN-1:0]  i_val,
    input  logic [HI-LO:0]   i_amt,
    input  logic             i_right,
    input  logic             i_fill,
    output logic [XLEN-1:0]  o_val
);

    logic [6:0]        w_amt;
    logic [2*XLEN-1:0] w_wide;

    assign w_amt  = 7'(i_amt) << LO;
    assign w_wide = {{XLEN{i_fill}}, i_val} >> w_amt;
    assign o_val  = i_right ? w_wide[XLEN-1:0] : (i_val << w_amt);

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined RV64 shift unit: low amount bits before stage A, high bits before stage B,
// then W-variant sign extension. Valid/ready handshake on both sides, flush kills in-flight ops.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    shift_unit_pipe_if.slave  bus
);

    logic             w_word;
    logic             w_fill;
    logic [XLEN-1:0]  w_a_in;
    logic [XLEN-1:0]  w_a_shift;
    logic [5:0]       w_amt;
    logic [XLEN-1:0]  w_b_shift;
    logic [XLEN-1:0]  w_b_result;
    logic             w_a_en;
    logic             w_b_en;
    logic             w_accept;

    logic             r_a_vld;
    logic [XLEN-1:0]  r_a_val;
    logic [2:0]       r_a_op;
    logic             r_a_fill;
    logic [2:0]       r_a_amt_hi;
    logic [TAG_W-1:0] r_a_tag;

    logic             r_b_vld;
    logic [XLEN-1:0]  r_b_result;
    logic [TAG_W-1:0] r_b_tag;

    // W ops pre-fill the upper word so right-shift fill enters from bit 63
    assign w_word = bus.in_op[2];
    assign w_fill = bus.in_op[1] & (w_word ? bus.in_rs1[31] : bus.in_rs1[63]);
    assign w_a_in = w_word ? {{32{w_fill}}, bus.in_rs1[31:0]} : bus.in_rs1;
    assign w_amt  = w_word ? {1'b0, bus.in_shamt[4:0]} : bus.in_shamt;

    assign w_b_en   = !r_b_vld || bus.out_ready;
    assign w_a_en   = !r_a_vld || w_b_en;
    assign w_accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready   = w_a_en && !flush;
    assign bus.out_valid  = r_b_vld;
    assign bus.out_result = r_b_result;
    assign bus.out_tag    = r_b_tag;

    shift_stage #(.LO(0), .HI(2)) u_stage_lo (
        .i_val   (w_a_in),
        .i_amt   (w_amt[2:0]),
        .i_right (bus.in_op[0]),
        .i_fill  (w_fill),
        .o_val   (w_a_shift)
    );

    // Stage A: bits [2:0] applied
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a_val    <= w_a_shift;
            r_a_op     <= bus.in_op;
            r_a_fill   <= w_fill;
            r_a_amt_hi <= w_amt[5:3];
            r_a_tag    <= bus.in_tag;
        end
    end

    shift_stage #(.LO(3), .HI(5)) u_stage_hi (
        .i_val   (r_a_val),
        .i_amt   (r_a_amt_hi),
        .i_right (r_a_op[0]),
        .i_fill  (r_a_fill),
        .o_val   (w_b_shift)
    );

    // Codes 010 and 110 (arith set without right) are undefined and produce zero
    assign w_b_result = (r_a_op[1] && !r_a_op[0]) ? '0 :
                        r_a_op[2] ? sext32(w_b_shift[31:0]) : w_b_shift;

    // Stage B: bits [5:3] applied and W result sign-extended
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_vld    <= 1'b0;
            r_b_vld    <= 1'b0;
            r_b_result <= '0;
            r_b_tag    <= '0;
        end else begin
            if (flush) begin
                r_a_vld <= 1'b0;
                r_b_vld <= 1'b0;
            end else begin
                if (w_a_en) r_a_vld <= w_accept;
                if (w_b_en) r_b_vld <= r_a_vld;
            end
            if (w_b_en && r_a_vld) begin
                r_b_result <= w_b_result;
                r_b_tag    <= r_a_tag;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: directed corner cases, stall/flush/reset scenarios and a
// randomized stream scored against an arithmetic reference model.
module tb_shift_unit_pipe;
    localparam int TAG_W = 5;

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    bit   seen_not_ready;
    exp_t q[$];

    shift_unit_pipe_if #(.TAG_W(TAG_W)) ifc ();

    shift_unit_pipe #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a,
                                              input logic [5:0] sh);
        logic [31:0]        w;
        logic signed [63:0] s;
        logic signed [31:0] sw;
        case (op)
            3'b000: return a << sh;
            3'b001: return a >> sh;
            3'b011: begin s = a; s = s >>> sh; return s; end
            3'b100: begin w = a[31:0] << sh[4:0]; return {{32{w[31]}}, w}; end
            3'b101: begin w = a[31:0] >> sh[4:0]; return {{32{w[31]}}, w}; end
            3'b111: begin sw = a[31:0]; sw = sw >>> sh[4:0]; return {{32{sw[31]}}, sw}; end
            default: return 64'h0;
        endcase
    endfunction

    // One clock of scoreboarded traffic; inputs must already be driven.
    task automatic step();
        logic             stl;
        logic [63:0]      pr;
        logic [TAG_W-1:0] pt;
        exp_t             e;
        #1;
        stl = 1'b0;
        pr  = ifc.out_result;
        pt  = ifc.out_tag;
        if (rst) begin
            q.delete();
        end else if (flush) begin
            n_vec++;
            if (ifc.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL flush_in_ready got %b exp 0", ifc.in_ready);
            end
            q.delete();
        end else begin
            if (ifc.in_valid && !ifc.in_ready) seen_not_ready = 1'b1;
            if (ifc.out_valid && ifc.out_ready) begin
                n_vec++;
                n_out++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_output got result %h tag %h exp none",
                             ifc.out_result, ifc.out_tag);
                end else begin
                    e = q.pop_front();
                    if (ifc.out_result !== e.res || ifc.out_tag !== e.tag) begin
                        n_err++;
                        $display("FAIL result got %h/%h exp %h/%h",
                                 ifc.out_result, ifc.out_tag, e.res, e.tag);
                    end
                end
            end
            if (ifc.in_valid && ifc.in_ready) begin
                e.res = ref_model(ifc.in_op, ifc.in_rs1, ifc.in_shamt);
                e.tag = ifc.in_tag;
                q.push_back(e);
            end
            stl = ifc.out_valid && !ifc.out_ready;
        end
        @(posedge clk);
        #1;
        if (stl && !rst && !flush) begin
            n_vec++;
            if (ifc.out_valid !== 1'b1 || ifc.out_result !== pr || ifc.out_tag !== pt) begin
                n_err++;
                $display("FAIL stall_hold got %b/%h/%h exp 1/%h/%h",
                         ifc.out_valid, ifc.out_result, ifc.out_tag, pr, pt);
            end
        end
    endtask

    task automatic rand_op();
        ifc.in_op    = 3'($urandom_range(0, 7));
        ifc.in_rs1   = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       ifc.in_shamt = 6'd0;
            1:       ifc.in_shamt = 6'd63;
            2:       ifc.in_shamt = 6'd31;
            default: ifc.in_shamt = 6'($urandom);
        endcase
        ifc.in_tag   = TAG_W'($urandom);
    endtask

    task automatic drain(input int budget);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < budget && q.size() != 0; i++) step();
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout got %0d pending exp 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.in_op = 3'b000;
        ifc.in_rs1 = '0;
        ifc.in_shamt = '0;
        ifc.in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (ifc.out_valid !== 1'b0 || ifc.out_result !== 64'h0 || ifc.out_tag !== '0 ||
            ifc.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state got v%b r%h t%h rdy%b exp v0 r0 t0 rdy1",
                     ifc.out_valid, ifc.out_result, ifc.out_tag, ifc.in_ready);
        end
    endtask

    task automatic check_op(input logic [2:0] op, input logic [63:0] rs1, input logic [5:0] sh,
                            input logic [63:0] exp_res, input string name);
        logic [TAG_W-1:0] t;
        t = TAG_W'($urandom);
        ifc.in_valid = 1'b1;
        ifc.in_op = op;
        ifc.in_rs1 = rs1;
        ifc.in_shamt = sh;
        ifc.in_tag = t;
        ifc.out_ready = 1'b1;
        #1;
        n_vec++;
        if (ifc.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ready got %b exp 1", name, ifc.in_ready);
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        n_vec++;
        if (ifc.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_early got out_valid %b exp 0", name, ifc.out_valid);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (ifc.out_valid !== 1'b1 || ifc.out_result !== exp_res || ifc.out_tag !== t) begin
            n_err++;
            $display("FAIL %s got v%b %h/%h exp v1 %h/%h", name, ifc.out_valid,
                     ifc.out_result, ifc.out_tag, exp_res, t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        check_op(3'b011, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, "sra63");
        check_op(3'b101, 64'hFFFF_FFFF_8000_0000, 6'd31, 64'h0000_0000_0000_0001, "srlw31");
        check_op(3'b111, 64'hFFFF_FFFF_8000_0000, 6'd31, 64'hFFFF_FFFF_FFFF_FFFF, "sraw31");
        check_op(3'b100, 64'h1, 6'd63, 64'hFFFF_FFFF_8000_0000, "sllw_b5");
        check_op(3'b000, 64'h1, 6'd63, 64'h8000_0000_0000_0000, "sll63");
        check_op(3'b001, 64'h8000_0000_0000_0000, 6'd63, 64'h1, "srl63");
        check_op(3'b000, 64'h1234_5678_9ABC_DEF0, 6'd0, 64'h1234_5678_9ABC_DEF0, "sll0");
        check_op(3'b101, 64'h0000_0000_8765_4321, 6'd0, 64'hFFFF_FFFF_8765_4321, "srlw0");
        check_op(3'b010, 64'hDEAD_BEEF_DEAD_BEEF, 6'd5, 64'h0, "undef010");
        check_op(3'b110, 64'hDEAD_BEEF_DEAD_BEEF, 6'd9, 64'h0, "undef110");
    endtask

    task automatic test_stall();
        int sent;
        int out0;
        sent = 0;
        out0 = n_out;
        seen_not_ready = 1'b0;
        for (int c = 0; c < 60 && (n_out - out0) < 8; c++) begin
            ifc.in_valid = (sent < 8);
            rand_op();
            ifc.out_ready = !(c >= 3 && c <= 5);
            #1;
            if (ifc.in_valid && ifc.in_ready) sent++;
            step();
        end
        ifc.in_valid = 1'b0;
        n_vec++;
        if ((n_out - out0) != 8 || q.size() != 0) begin
            n_err++;
            $display("FAIL stall_count got %0d out %0d pending exp 8 out 0 pending",
                     n_out - out0, q.size());
        end
        n_vec++;
        if (!seen_not_ready) begin
            n_err++;
            $display("FAIL stall_backpressure got in_ready never low exp low once");
        end
    endtask

    task automatic test_flush();
        int out0;
        ifc.out_ready = 1'b0;
        ifc.in_valid = 1'b1;
        rand_op();
        step();
        rand_op();
        step();
        flush = 1'b1;
        rand_op();
        step();
        flush = 1'b0;
        ifc.in_valid = 1'b0;
        n_vec++;
        if (ifc.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_out_valid got %b exp 0", ifc.out_valid);
        end
        out0 = n_out;
        ifc.in_valid = 1'b1;
        rand_op();
        step();
        drain(10);
        n_vec++;
        if (n_out - out0 != 1) begin
            n_err++;
            $display("FAIL flush_after got %0d results exp 1", n_out - out0);
        end
    endtask

    task automatic test_reset_mid();
        ifc.out_ready = 1'b1;
        ifc.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_op();
            step();
        end
        rst = 1'b1;
        rand_op();
        step();
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        #1;
        n_vec++;
        if (ifc.out_valid !== 1'b0 || ifc.out_result !== 64'h0 || ifc.out_tag !== '0 ||
            ifc.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid got v%b r%h t%h rdy%b exp v0 r0 t0 rdy1",
                     ifc.out_valid, ifc.out_result, ifc.out_tag, ifc.in_ready);
        end
        step();
        n_vec++;
        if (ifc.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_ghost got out_valid %b exp 0", ifc.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int out0;
        out0 = n_out;
        ifc.out_ready = 1'b1;
        ifc.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_op();
            step();
        end
        ifc.in_valid = 1'b0;
        step();
        n_vec++;
        if (n_out - out0 != 5 || ifc.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_back got %0d results v%b exp 5 v1", n_out - out0, ifc.out_valid);
        end
        drain(10);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            ifc.in_valid = ($urandom_range(0, 3) != 0);
            rand_op();
            ifc.out_ready = ($urandom_range(0, 4) != 0);
            flush = ($urandom_range(0, 99) == 0);
            step();
        end
        flush = 1'b0;
        drain(20);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
